// File: rtl/imem_if.sv
// Instruction fetch bus between the fetch stage (cpu) and the instruction memory (mem).
// The cpu side presents a PC every cycle and the mem side answers with the
// instruction word combinationally in the same cycle. There is no handshake:
// the fetch stage is held off through o_cpu_hold until the store is loaded.
interface imem_if #(
    parameter int NB_ADDR = 32,
    parameter int NB_WORD = 32
);
    logic [NB_ADDR-1:0] imem_pc;
    logic [NB_WORD-1:0] imem_instruction;

    modport cpu (output imem_pc, input imem_instruction);
    modport mem (input imem_pc, output imem_instruction);
endinterface

// File: rtl/imem_responder.sv
// Instruction-memory responder: a word store filled by a little-endian byte
// boot loader, then served to the fetch stage with zero-latency reads.
// Loader handshake: a byte transfers on a rising edge where i_load_valid and
// o_load_ready are both high; i_load_last is only meaningful with i_load_valid.
module imem_responder #(
    parameter int                DEPTH    = 1024,
    parameter logic [31:0]       NOP_WORD = 32'h0000_0013,
    parameter int                NB_ADDR  = 32
) (
    input  logic               i_clock,
    input  logic               i_reset,
    imem_if.mem                IMEM_IF,
    input  logic               i_load_valid,
    input  logic [7:0]         i_load_data,
    input  logic               i_load_last,
    output logic               o_load_ready,
    output logic               o_cpu_hold,
    output logic               o_load_err,
    output logic               o_fault,
    output logic [NB_ADDR-1:0] o_fault_addr,
    output logic               o_dbg_run
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [1:0]         byte_cnt;
    logic [NB_ADDR-1:0] word_addr;
    logic [31:0]        asm_q;
    logic [31:0]        mem [DEPTH];

    logic               load_fire;
    logic               in_store;
    logic               word_done;
    logic [31:0]        merged_word;
    logic [NB_ADDR-1:0] pc;
    logic               pc_ok;

    // Loader datapath terms. The assembly register is cleared after every
    // written word, so a short final word is naturally zero-padded.
    always_comb begin
        load_fire   = (state_q == ST_LOAD) && i_load_valid;
        in_store    = word_addr < NB_ADDR'(DEPTH);
        word_done   = load_fire && ((byte_cnt == 2'd3) || i_load_last);
        merged_word = asm_q | ({24'b0, i_load_data} << {byte_cnt, 3'b000});
    end

    // Fetch address check at full PC width, so no high address aliases into the store.
    always_comb begin
        pc    = IMEM_IF.imem_pc;
        pc_ok = (pc[1:0] == 2'b00) && ((pc >> 2) < NB_ADDR'(DEPTH));
    end

    // State register.
    always_ff @(posedge i_clock) begin
        if (i_reset) state_q <= ST_LOAD;
        else         state_q <= state_d;
    end

    // Next state and handshake outputs; LOAD holds the CPU and accepts bytes.
    always_comb begin
        state_d      = state_q;
        o_load_ready = 1'b0;
        o_cpu_hold   = 1'b0;
        case (state_q)
            ST_LOAD: begin
                o_load_ready = 1'b1;
                o_cpu_hold   = 1'b1;
                if (load_fire && i_load_last) state_d = ST_RUN;
            end
            ST_RUN: begin
                o_load_ready = 1'b0;
                o_cpu_hold   = 1'b0;
            end
            default: state_d = ST_LOAD;
        endcase
    end

    assign o_dbg_run = (state_q == ST_RUN);

    // Byte assembly and write pointer. Once the pointer reaches DEPTH it stops,
    // and every further byte is dropped and flagged as an overflow.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            byte_cnt   <= 2'd0;
            word_addr  <= '0;
            asm_q      <= 32'd0;
            o_load_err <= 1'b0;
        end else if (load_fire) begin
            byte_cnt <= byte_cnt + 2'd1;
            asm_q    <= word_done ? 32'd0 : merged_word;
            if (!in_store) o_load_err <= 1'b1;
            if (word_done && in_store) word_addr <= word_addr + 1'b1;
        end
    end

    // Store write port; contents survive reset.
    always_ff @(posedge i_clock) begin
        if (word_done && in_store) mem[word_addr[AW-1:0]] <= merged_word;
    end

    // Asynchronous read port, only visible once the load has finished.
    always_comb begin
        IMEM_IF.imem_instruction = NOP_WORD;
        if ((state_q == ST_RUN) && pc_ok) IMEM_IF.imem_instruction = mem[pc[AW+1:2]];
    end

    // Sticky fault flag; only the first bad fetch address is kept.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_fault      <= 1'b0;
            o_fault_addr <= '0;
        end else if ((state_q == ST_RUN) && !pc_ok && !o_fault) begin
            o_fault      <= 1'b1;
            o_fault_addr <= pc;
        end
    end
endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder with a small store (DEPTH=4) so overflow is cheap to reach.
module tb_imem_responder;
    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        i_clock = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_load_valid = 1'b0;
    logic [7:0]  i_load_data = 8'h00;
    logic        i_load_last = 1'b0;
    logic        o_load_ready;
    logic        o_cpu_hold;
    logic        o_load_err;
    logic        o_fault;
    logic [31:0] o_fault_addr;
    logic        o_dbg_run;

    imem_if #(.NB_ADDR(32), .NB_WORD(32)) bus ();

    imem_responder #(.DEPTH(DEPTH), .NOP_WORD(NOP), .NB_ADDR(32)) dut (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .IMEM_IF      (bus.mem),
        .i_load_valid (i_load_valid),
        .i_load_data  (i_load_data),
        .i_load_last  (i_load_last),
        .o_load_ready (o_load_ready),
        .o_cpu_hold   (o_cpu_hold),
        .o_load_err   (o_load_err),
        .o_fault      (o_fault),
        .o_fault_addr (o_fault_addr),
        .o_dbg_run    (o_dbg_run)
    );

    // Clock.
    always #5 i_clock = ~i_clock;

    // Reference model: the image as a byte stream laid into words.
    logic [31:0] model_mem [DEPTH];
    bit          model_known [DEPTH];
    bit          m_load;
    int          m_pos;
    bit          m_err;
    bit          m_fault;
    logic [31:0] m_fault_addr;
    logic [7:0]  m_pend [$];
    logic [7:0]  img_q [$];
    logic [31:0] exp_q [$];
    int          n_cmp = 0;
    int          n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clock);
        #1;
    endtask

    task automatic do_reset();
        i_reset      = 1'b1;
        i_load_valid = 1'b0;
        bus.imem_pc  = 32'd0;
        step();
        i_reset      = 1'b0;
        m_load       = 1'b1;
        m_pos        = 0;
        m_err        = 1'b0;
        m_fault      = 1'b0;
        m_fault_addr = 32'd0;
        m_pend.delete();
        check1("rst_ready", o_load_ready, 1'b1);
        check1("rst_hold", o_cpu_hold, 1'b1);
        check1("rst_err", o_load_err, 1'b0);
        check1("rst_fault", o_fault, 1'b0);
        check("rst_fault_addr", o_fault_addr, 32'd0);
        check("rst_instr", bus.imem_instruction, NOP);
    endtask

    // Little-endian word from the pending bytes, upper bytes zero.
    task automatic model_commit();
        logic [31:0] w;
        int idx;
        w = 32'd0;
        for (int i = 0; i < m_pend.size(); i++) w[8*i +: 8] = m_pend[i];
        idx = (m_pos - 1) / 4;
        if (idx < DEPTH) begin
            model_mem[idx]   = w;
            model_known[idx] = 1'b1;
        end
        m_pend.delete();
    endtask

    task automatic send_byte(input logic [7:0] d, input bit last, input int gap);
        repeat (gap) begin
            i_load_valid = 1'b0;
            i_load_data  = 8'($urandom);
            i_load_last  = 1'($urandom);
            step();
        end
        i_load_valid = 1'b1;
        i_load_data  = d;
        i_load_last  = last;
        #1;
        if (m_load) begin
            check1("load_ready", o_load_ready, 1'b1);
            check1("load_hold", o_cpu_hold, 1'b1);
            check("load_nop", bus.imem_instruction, NOP);
        end
        step();
        if (m_load) begin
            m_pend.push_back(d);
            if (m_pos / 4 >= DEPTH) m_err = 1'b1;
            m_pos++;
            if (m_pend.size() == 4 || last) model_commit();
            if (last) m_load = 1'b0;
        end
        i_load_valid = 1'b0;
        i_load_last  = 1'b0;
    endtask

    task automatic load_image(input int max_gap);
        for (int i = 0; i < img_q.size(); i++)
            send_byte(img_q[i], i == img_q.size() - 1, $urandom_range(0, max_gap));
        check1("run_hold", o_cpu_hold, 1'b0);
        check1("run_ready", o_load_ready, 1'b0);
        check1("load_err", o_load_err, m_err);
    endtask

    task automatic fetch(input logic [31:0] pc, output logic [31:0] obs);
        logic [31:0] exp;
        bit known;
        bit good;
        good  = (pc % 4 == 0) && (pc < DEPTH * 4);
        known = 1'b1;
        if (m_load || !good) exp = NOP;
        else begin
            exp   = model_mem[pc / 4];
            known = model_known[pc / 4];
        end
        bus.imem_pc = pc;
        #1;
        obs = bus.imem_instruction;
        if (known) begin
            exp_q.push_back(exp);
            check("fetch", obs, exp_q.pop_front());
        end
        if (!m_load && !good && !m_fault) begin
            m_fault      = 1'b1;
            m_fault_addr = pc;
        end
        step();
        bus.imem_pc = 32'd0;
        check1("fault", o_fault, m_fault);
        check("fault_addr", o_fault_addr, m_fault_addr);
    endtask

    function automatic logic [31:0] rand_pc();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, DEPTH - 1) * 4);
            1:       return 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
            2:       return 32'(DEPTH * 4 + $urandom_range(0, 64));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] obs;
        for (int i = 0; i < DEPTH; i++) model_known[i] = 1'b0;
        bus.imem_pc = 32'd0;

        // Two-instruction image.
        do_reset();
        img_q = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'hB0, 8'h00};
        load_image(0);
        fetch(32'd0, obs);
        check("img_w0", obs, 32'h00A0_0513);
        fetch(32'd4, obs);
        check("img_w1", obs, 32'h00B0_0593);

        // Partial final word is zero-padded.
        do_reset();
        img_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        load_image(1);
        fetch(32'd4, obs);
        check("pad_w1", obs, 32'h0000_0605);

        // Overflow: 20 bytes into a 4-word store.
        do_reset();
        img_q.delete();
        for (int i = 0; i < 20; i++) img_q.push_back(8'(8'h10 + i));
        load_image(0);
        check1("ovf_err", o_load_err, 1'b1);
        fetch(32'd12, obs);
        check("ovf_w3", obs, 32'h1F1E_1D1C);

        // Fault capture keeps the first address.
        fetch(32'h2, obs);
        check("fault_nop", obs, NOP);
        check("fault_first", o_fault_addr, 32'h2);
        fetch(32'(DEPTH * 4), obs);
        fetch(32'hFFFF_FFF0, obs);
        check("fault_kept", o_fault_addr, 32'h2);

        // Reset after three bytes aborts the word.
        do_reset();
        send_byte(8'h11, 1'b0, 0);
        send_byte(8'h22, 1'b0, 0);
        send_byte(8'h33, 1'b0, 0);
        do_reset();
        img_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        load_image(0);
        fetch(32'd0, obs);
        check("reload_w0", obs, 32'hEFBE_ADDE);

        // Bubbles during load, then bytes offered in RUN are ignored.
        do_reset();
        img_q.delete();
        for (int i = 0; i < 9; i++) img_q.push_back(8'($urandom));
        load_image(3);
        for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'($urandom), 0);
        for (int i = 0; i < DEPTH; i++) fetch(32'(i * 4), obs);

        // Random images, aborted loads and fetches.
        for (int it = 0; it < 8; it++) begin
            do_reset();
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < $urandom_range(1, 7); i++) send_byte(8'($urandom), 1'b0, 0);
                do_reset();
            end
            img_q.delete();
            for (int i = 0; i < $urandom_range(1, DEPTH * 4 + 6); i++) img_q.push_back(8'($urandom));
            load_image(2);
            for (int i = 0; i < 10; i++) fetch(rand_pc(), obs);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder: the memory end of imem_if, serving the fetch stage's PC requests with instruction words.
- Contains a word-array instruction store that is filled after reset by a byte-stream boot loader (valid/ready).
- Holds the CPU until loading completes, then answers fetches combinationally in the same cycle.
- Flags misaligned and out-of-range fetch addresses, substituting a NOP.

Parameters:
- DEPTH, 1024, number of 32-bit words in the instruction store; power of two, at least 4.
- NOP_WORD, 32'h0000_0013, word returned for any fetch not served from the store (ADDI x0,x0,0).

Ports:
- i_clock  input  1  clock.
- i_reset  input  1  synchronous, active-high reset.
- IMEM_IF  imem_if.mem modport  -  reads imem_pc (NB_ADDR bits) and drives imem_instruction (NB_WORD bits).
- i_load_valid  input  1  boot byte valid.
- i_load_data  input  8  boot byte, little-endian within each word.
- i_load_last  input  1  marks the final byte of the image; qualified by i_load_valid.
- o_load_ready  output  1  loader accepts a byte this cycle.
- o_cpu_hold  output  1  keeps the CPU in reset/stall while high.
- o_load_err  output  1  sticky: the image exceeded DEPTH words.
- o_fault  output  1  sticky: a fetch was made to a misaligned or out-of-range address.
- o_fault_addr  output  NB_ADDR  PC of the first faulting fetch.

Behaviour:
- State machine has two states, LOAD and RUN. Reset enters LOAD.
- Reset values: state=LOAD, byte_cnt=0, word_addr=0, assembly register=0, o_load_err=0, o_fault=0, o_fault_addr=0.
- Output values after reset: o_load_ready=1 and o_cpu_hold=1.
- Reset does not clear store contents. Reset mid-load aborts the load; the next load restarts at word 0.
- A byte is accepted when i_load_valid and o_load_ready are both high.
  - Byte k of a word (k = byte_cnt) goes into bits [8k+7:8k].
  - byte_cnt increments modulo 4.
  - On k=3, the completed word is written to mem[word_addr] at that clock edge and word_addr increments.
- Accepted byte with i_load_last=1:
  - The word is written with any unfilled upper bytes zero-padded.
  - The transition to RUN happens on the same edge.
  - A last byte that completes an exact word causes one write, not two.
- Overflow: if word_addr==DEPTH, further bytes are accepted and discarded, o_load_err sets, and i_load_last still moves the block to RUN.
- word_addr is NB_ADDR wide, so it does not wrap at DEPTH.
- LOAD outputs: o_load_ready=1, o_cpu_hold=1, imem_instruction=NOP_WORD.
- RUN outputs: o_load_ready=0, o_cpu_hold=0 starting the cycle after the last byte is accepted. Bytes presented in RUN are ignored. Only i_reset returns the block to LOAD.
- Fetch in RUN is zero-latency combinational:
  - If imem_pc[1:0]==0 and imem_pc < DEPTH*4, imem_instruction = mem[imem_pc >> 2].
  - Otherwise imem_instruction = NOP_WORD. Compare at full NB_ADDR width, with no truncation-based aliasing.
- Fault capture:
  - On the first RUN cycle with a bad address, o_fault sets on the next edge and o_fault_addr captures imem_pc.
  - Later faults do not overwrite o_fault_addr.
  - Faults are not detected in LOAD.
- A write and a fetch never happen in the same cycle, because the two states are exclusive. The store needs only a single write port and an asynchronous read port.

Test Plan:
- Reset, then stream the 8 bytes 13 05 A0 00 93 05 B0 00 with last on byte 8.
  - mem[0]=0x00A00513 and mem[1]=0x00B00593.
  - o_cpu_hold falls the cycle after the last byte.
  - pc=0 returns 0x00A00513 and pc=4 returns 0x00B00593.
- Stream 6 bytes 01 02 03 04 05 06 with last on byte 6 → mem[1]=0x00000605 and RUN is entered.
- With DEPTH=4, stream 20 bytes with last on byte 20.
  - Words 0-3 are written and the remaining 4 bytes are dropped.
  - o_load_err=1 and RUN is entered.
- In RUN:
  - Fetch pc=0x2 → NOP 0x00000013, o_fault=1, o_fault_addr=0x2.
  - Then fetch pc=DEPTH*4 → NOP, and o_fault_addr stays 0x2.
- Assert i_reset after 3 of 4 bytes have been accepted, then reload 4 bytes DE AD BE EF.
  - mem[0]=0xEFBEADDE.
  - o_load_ready=1 throughout LOAD, and imem_instruction=NOP_WORD until RUN.
- Toggle i_load_valid with gaps during a load (bubbles) → assembly is unaffected.
  - After RUN, further valid bytes do not modify memory (mem[0] unchanged).
